// File: rtl/video_test_pattern_generator.sv
// video_test_pattern_generator
//   Pixel-colour source for the video pipeline. For each requested (hPos, vPos)
//   it returns an RGB test-pattern colour LATENCY clocks later, so the pipeline
//   can be exercised on hardware without a real video source.
// Ports
//   scalerClock        sole clock
//   reset              asynchronous, active-low
//   patternSelect      0 solid, 1 bars, 2 checker, 3 gradient, 4 moving box, 5-7 black
//   solidColor         {R,G,B} used by pattern 0
//   barShift           bar index = hPos >> barShift (clamped to 7)
//   checkShift         checker cell edge = 1 << checkShift pixels
//   hPos, vPos         requested pixel coordinates
//   dataEnable         hPos/vPos valid this clock
//   r, g, b            pixel colour, forced to 0 when dataEnableDelayed is low
//   dataEnableDelayed  dataEnable delayed LATENCY clocks
//   frameCount         frame starts seen since reset (wraps)
module video_test_pattern_generator #(
  parameter int HACTIVE_BITS  = 11,
  parameter int VACTIVE_BITS  = 11,
  parameter int LATENCY       = 2,
  parameter int BOX_SIZE_BITS = 5
) (
  input  logic                    scalerClock,
  input  logic                    reset,
  input  logic [2:0]              patternSelect,
  input  logic [23:0]             solidColor,
  input  logic [3:0]              barShift,
  input  logic [3:0]              checkShift,
  input  logic [HACTIVE_BITS-1:0] hPos,
  input  logic [VACTIVE_BITS-1:0] vPos,
  input  logic                    dataEnable,
  output logic [7:0]              r,
  output logic [7:0]              g,
  output logic [7:0]              b,
  output logic                    dataEnableDelayed,
  output logic [15:0]             frameCount
);

  // Stage 2 plus any extra pure-delay stages.
  localparam int PIPE_DEPTH = LATENCY - 1;

  // Frame-level state
  logic [15:0] frame_count_q, frame_count_d;
  logic [8:0]  frame_latched_q, frame_latched_d;   // only the bits the box origin uses
  logic [2:0]  active_pattern_q, active_pattern_d;

  // Stage 1
  logic                    s1_de_q, s1_de_d;
  logic [HACTIVE_BITS-1:0] s1_h_q, s1_h_d;
  logic [VACTIVE_BITS-1:0] s1_v_q, s1_v_d;
  logic [2:0]              s1_pat_q, s1_pat_d;
  logic [2:0]              s1_bar_q, s1_bar_d;
  logic [HACTIVE_BITS-1:0] s1_bx_q, s1_bx_d;
  logic [VACTIVE_BITS-1:0] s1_by_q, s1_by_d;

  // Stage 2 and delay line: {de, r, g, b}
  logic [24:0] pix_q [PIPE_DEPTH];
  logic [24:0] pix_d [PIPE_DEPTH];

  logic                    frame_start;
  logic [2:0]              eff_pattern;
  logic [8:0]              eff_frame;
  logic [HACTIVE_BITS-1:0] bar_full;
  logic [HACTIVE_BITS-1:0] dx;
  logic [VACTIVE_BITS-1:0] dy;
  logic                    in_box;
  logic                    h_chk;
  logic                    v_chk;
  logic [23:0]             rgb;

  // Frame tracking and stage 1. The pixel that starts a frame already uses the
  // new pattern/frame, so the whole frame is drawn with one consistent setting.
  always_comb begin
    frame_start      = dataEnable && (hPos == '0) && (vPos == '0);
    eff_pattern      = frame_start ? patternSelect : active_pattern_q;
    eff_frame        = frame_start ? frame_count_q[8:0] : frame_latched_q;

    frame_count_d    = frame_start ? frame_count_q + 16'd1 : frame_count_q;
    frame_latched_d  = frame_start ? frame_count_q[8:0] : frame_latched_q;
    active_pattern_d = frame_start ? patternSelect : active_pattern_q;

    bar_full = hPos >> barShift;
    s1_bar_d = (bar_full > HACTIVE_BITS'(7)) ? 3'd7 : bar_full[2:0];
    s1_de_d  = dataEnable;
    s1_h_d   = hPos;
    s1_v_d   = vPos;
    s1_pat_d = eff_pattern;
    s1_bx_d  = HACTIVE_BITS'({eff_frame[7:0], 2'b00});
    s1_by_d  = VACTIVE_BITS'({eff_frame, 1'b0});
  end

  // Stage 2 colour generation and delay line.
  always_comb begin
    // Modular subtraction lets the box wrap across the screen edges.
    dx     = s1_h_q - s1_bx_q;
    dy     = s1_v_q - s1_by_q;
    in_box = ((dx >> BOX_SIZE_BITS) == '0) && ((dy >> BOX_SIZE_BITS) == '0);
    // Cell bits beyond the coordinate width read as 0.
    h_chk  = (32'(checkShift) < HACTIVE_BITS) ? s1_h_q[checkShift] : 1'b0;
    v_chk  = (32'(checkShift) < VACTIVE_BITS) ? s1_v_q[checkShift] : 1'b0;

    rgb = 24'h000000;
    case (s1_pat_q)
      3'd0: rgb = solidColor;
      3'd1: rgb = {{8{~s1_bar_q[1]}}, {8{~s1_bar_q[2]}}, {8{~s1_bar_q[0]}}};
      3'd2: rgb = (h_chk ^ v_chk) ? 24'hFFFFFF : 24'h000000;
      3'd3: rgb = {s1_h_q[7:0], s1_v_q[7:0], s1_h_q[7:0] ^ s1_v_q[7:0]};
      3'd4: rgb = in_box ? 24'hFFFFFF : 24'h000000;
      default: rgb = 24'h000000;
    endcase
    if (!s1_de_q) rgb = 24'h000000;

    pix_d[0] = {s1_de_q, rgb};
    for (int k = 1; k < PIPE_DEPTH; k++) pix_d[k] = pix_q[k-1];
  end

  always_ff @(posedge scalerClock or negedge reset) begin
    if (!reset) begin
      frame_count_q    <= '0;
      frame_latched_q  <= '0;
      active_pattern_q <= '0;
      s1_de_q          <= 1'b0;
      s1_h_q           <= '0;
      s1_v_q           <= '0;
      s1_pat_q         <= '0;
      s1_bar_q         <= '0;
      s1_bx_q          <= '0;
      s1_by_q          <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) pix_q[k] <= '0;
    end else begin
      frame_count_q    <= frame_count_d;
      frame_latched_q  <= frame_latched_d;
      active_pattern_q <= active_pattern_d;
      s1_de_q          <= s1_de_d;
      s1_h_q           <= s1_h_d;
      s1_v_q           <= s1_v_d;
      s1_pat_q         <= s1_pat_d;
      s1_bar_q         <= s1_bar_d;
      s1_bx_q          <= s1_bx_d;
      s1_by_q          <= s1_by_d;
      for (int k = 0; k < PIPE_DEPTH; k++) pix_q[k] <= pix_d[k];
    end
  end

  assign dataEnableDelayed = pix_q[PIPE_DEPTH-1][24];
  assign r                 = pix_q[PIPE_DEPTH-1][23:16];
  assign g                 = pix_q[PIPE_DEPTH-1][15:8];
  assign b                 = pix_q[PIPE_DEPTH-1][7:0];
  assign frameCount        = frame_count_q;

endmodule
